// File: rtl/clock_div_ctrl.sv
// Programmable divided-clock generator: period/high time set through a
// valid/ready port, new settings take effect only at a period boundary.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | stopped, clk_out low, counter held at zero
// S_HIGH | clk_out high, counting cycles 0 .. high-1 of the period
// S_LOW  | clk_out low, counting cycles high .. period-1 of the period
module clock_div_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEF_PERIOD = 10,
  parameter int unsigned DEF_HIGH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_high;
  logic             r_pend_valid;
  logic             r_clk_out;
  logic             r_cfg_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_high_nxt;
  logic [CNT_W-1:0] w_pend_period_nxt;
  logic [CNT_W-1:0] w_pend_high_nxt;
  logic             w_pend_valid_nxt;
  logic             w_cfg_err_nxt;

  logic w_xfer;
  logic w_legal;
  logic w_high_end;
  logic w_period_end;
  logic w_boundary;
  logic w_direct;

  assign w_xfer       = cfg_valid && !r_pend_valid;
  assign w_legal      = (cfg_period >= TWO) && (cfg_high != '0) && (cfg_high < cfg_period);
  assign w_high_end   = (r_cnt == r_high - ONE);
  assign w_period_end = (r_cnt == r_period - ONE);
  assign w_boundary   = ((r_state == S_IDLE) && enb) || ((r_state == S_LOW) && w_period_end);
  assign w_direct     = (r_state == S_IDLE) && !enb;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk_out;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (enb) begin
          w_state_nxt = S_HIGH;
          w_clk_nxt   = 1'b1;
        end
      end
      S_HIGH: begin
        w_cnt_nxt = r_cnt + ONE;
        if (w_high_end) begin
          w_state_nxt = S_LOW;
          w_clk_nxt   = 1'b0;
        end
      end
      S_LOW: begin
        if (w_period_end) begin
          w_cnt_nxt = '0;
          // enb is only looked at here, so a running period always completes
          if (enb) begin
            w_state_nxt = S_HIGH;
            w_clk_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_clk_nxt   = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  // A boundary copy needs pend_valid=1 and a transfer needs it 0, so they never collide.
  always_comb begin
    w_period_nxt      = r_period;
    w_high_nxt        = r_high;
    w_pend_period_nxt = r_pend_period;
    w_pend_high_nxt   = r_pend_high;
    w_pend_valid_nxt  = r_pend_valid;
    w_cfg_err_nxt     = w_xfer && !w_legal;
    if (w_boundary && r_pend_valid) begin
      w_period_nxt     = r_pend_period;
      w_high_nxt       = r_pend_high;
      w_pend_valid_nxt = 1'b0;
    end
    if (w_xfer && w_legal) begin
      if (w_direct) begin
        w_period_nxt = cfg_period;
        w_high_nxt   = cfg_high;
      end else begin
        w_pend_period_nxt = cfg_period;
        w_pend_high_nxt   = cfg_high;
        w_pend_valid_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_period      <= CNT_W'(DEF_PERIOD);
      r_high        <= CNT_W'(DEF_HIGH);
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_pend_valid  <= 1'b0;
      r_clk_out     <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_period      <= w_period_nxt;
      r_high        <= w_high_nxt;
      r_pend_period <= w_pend_period_nxt;
      r_pend_high   <= w_pend_high_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_clk_out     <= w_clk_nxt;
      r_cfg_err     <= w_cfg_err_nxt;
    end
  end

  assign cfg_ready = !r_pend_valid;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;
  assign running   = (r_state != S_IDLE);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl: vector table, hand-written corner sequences and
// a randomized run checked against a period-position reference model.
module tb_clock_div_ctrl;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic       clk_out;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  clock_div_ctrl #(.CNT_W(8), .DEF_PERIOD(10), .DEF_HIGH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: running flag plus position within the current period.
  bit m_run, m_pend, m_err, m_xfer;
  int m_pos, m_per, m_hi, m_pp, m_ph;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_err = 0; m_xfer = 0;
    m_pos = 0; m_per = 10; m_hi = 3; m_pp = 0; m_ph = 0;
  endtask

  task automatic model_edge();
    bit legal, bnd, run_old, direct;
    int p, h;
    p = int'(cfg_period);
    h = int'(cfg_high);
    run_old = m_run;
    m_xfer  = cfg_valid && !m_pend;
    legal   = (p >= 2) && (h >= 1) && (h < p);
    bnd     = run_old ? (m_pos == m_per - 1) : enb;
    direct  = !run_old && !enb;
    m_err   = m_xfer && !legal;
    if (run_old) begin
      if (m_pos == m_per - 1) begin
        m_pos = 0;
        m_run = enb;
      end else begin
        m_pos++;
      end
    end else if (enb) begin
      m_run = 1;
      m_pos = 0;
    end
    if (bnd && m_pend) begin
      m_per = m_pp; m_hi = m_ph; m_pend = 0;
    end else if (m_xfer && legal) begin
      if (direct) begin
        m_per = p; m_hi = h;
      end else begin
        m_pp = p; m_ph = h; m_pend = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input int nh, input int nl, input string nm);
    for (int i = 0; i < nh; i++) begin
      step();
      chk({nm, "_hi"}, 32'(clk_out), 32'd1);
    end
    for (int i = 0; i < nl; i++) begin
      step();
      chk({nm, "_lo"}, 32'(clk_out), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; enb = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
    model_reset();
    #2;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (running && k < 600) begin
      step();
      k++;
    end
    chk(nm, 32'(running), 32'd0);
  endtask

  typedef struct {
    logic       enb;
    logic       v;
    logic [7:0] p;
    logic [7:0] h;
    logic       e_clk;
    logic       e_run;
    logic       e_rdy;
    logic       e_err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit   offer;
    logic hi_ph;
    rst = 1'b1; enb = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;

    // Default 10/3 pattern, then two illegal offers while running
    for (int i = 0; i < 10; i++) begin
      hi_ph  = (i < 3);
      tbl[i] = '{1'b1, 1'b0, 8'd0, 8'd0, hi_ph, 1'b1, 1'b1, 1'b0};
    end
    tbl[10] = '{1'b1, 1'b1, 8'd5, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    foreach (tbl[i]) begin
      enb = tbl[i].enb; cfg_valid = tbl[i].v; cfg_period = tbl[i].p; cfg_high = tbl[i].h;
      step();
      chk($sformatf("vec%0d_clk", i), 32'(clk_out), 32'(tbl[i].e_clk));
      chk($sformatf("vec%0d_run", i), 32'(running), 32'(tbl[i].e_run));
      chk($sformatf("vec%0d_rdy", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
    end
    cfg_valid = 1'b0;

    // Reconfigure at cnt=2: current period finishes, then 4/2 with no gap
    do_reset();
    enb = 1'b1;
    step(); step(); step();
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("chg_ready_low", 32'(cfg_ready), 32'd0);
    chk("chg_pos3", 32'(clk_out), 32'd0);
    expect_run(0, 6, "chg_old");
    chk("chg_ready_hold", 32'(cfg_ready), 32'd0);
    expect_run(2, 2, "chg_new1");
    chk("chg_ready_back", 32'(cfg_ready), 32'd1);
    expect_run(2, 2, "chg_new2");
    expect_run(2, 2, "chg_new3");

    // Drop enb in HIGH: period completes, then idle; restart from cnt=0
    do_reset();
    enb = 1'b1;
    step(); step();
    enb = 1'b0;
    expect_run(1, 7, "stop");
    step();
    chk("stop_clk", 32'(clk_out), 32'd0);
    chk("stop_run", 32'(running), 32'd0);
    step();
    chk("stop_still", 32'(running), 32'd0);
    enb = 1'b1;
    step();
    chk("restart_clk", 32'(clk_out), 32'd1);
    chk("restart_run", 32'(running), 32'd1);
    expect_run(2, 7, "restart");

    // Async reset mid-HIGH with a pending config
    do_reset();
    enb = 1'b1;
    step(); step();
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("arst_pend", 32'(cfg_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_out), 32'd0);
    chk("arst_run", 32'(running), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("arst_start", 32'(clk_out), 32'd1);
    expect_run(2, 7, "arst_p1");
    expect_run(3, 7, "arst_p2");

    // Corner: period 2 / high 1 written directly in idle, then 255/254
    do_reset();
    cfg_valid = 1'b1; cfg_period = 8'd2; cfg_high = 8'd1;
    step();
    cfg_valid = 1'b0;
    chk("p2_direct_ready", 32'(cfg_ready), 32'd1);
    enb = 1'b1;
    expect_run(1, 1, "p2_a");
    expect_run(1, 1, "p2_b");
    expect_run(1, 1, "p2_c");
    enb = 1'b0;
    wait_idle("p2_idle");
    cfg_valid = 1'b1; cfg_period = 8'd255; cfg_high = 8'd254;
    step();
    cfg_valid = 1'b0;
    enb = 1'b1;
    expect_run(254, 1, "p255_a");
    expect_run(254, 1, "p255_b");
    enb = 1'b0;
    wait_idle("p255_idle");

    // Transfer on the boundary edge is applied one period later
    do_reset();
    enb = 1'b1;
    for (int i = 0; i < 10; i++) step();
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("bnd_clk", 32'(clk_out), 32'd1);
    chk("bnd_ready", 32'(cfg_ready), 32'd0);
    expect_run(2, 7, "bnd_old");
    expect_run(2, 2, "bnd_new");
    chk("bnd_ready_back", 32'(cfg_ready), 32'd1);

    // Randomized run against the reference model
    do_reset();
    offer = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) enb = ~enb;
      if (!offer && $urandom_range(0, 7) == 0) begin
        offer      = 1;
        cfg_valid  = 1'b1;
        cfg_period = 8'($urandom_range(0, 9));
        cfg_high   = 8'($urandom_range(0, int'(cfg_period)));
      end
      @(posedge clk);
      model_edge();
      #1;
      if (m_xfer) begin
        offer     = 0;
        cfg_valid = 1'b0;
      end
      chk("rnd_clk", 32'(clk_out), 32'(m_run && (m_pos < m_hi)));
      chk("rnd_run", 32'(running), 32'(m_run));
      chk("rnd_rdy", 32'(cfg_ready), 32'(!m_pend));
      chk("rnd_err", 32'(cfg_err), 32'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
